// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              dm_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_params
      $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic                owner_if_q, owner_if_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

   logic fetch_force;
   logic grant_if;
   logic grant_dm;

   // Data normally wins: it belongs to the older instruction in the pipeline.
   assign grant_if = if_req && (!dm_req || fetch_force);
   assign grant_dm = dm_req && !grant_if;

`ifdef ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

   assign fetch_force = if_req && (starve_cnt_q >= SC_W'(STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == IDLE) begin
         if (grant_if) begin
            starve_cnt_d = '0;
         end else if (grant_dm && if_req && (starve_cnt_q < SC_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
         end
      end
   end
`else
   assign fetch_force = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      owner_if_d  = owner_if_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         IDLE: begin
            if (grant_if || grant_dm) begin
               state_d     = ACCESS;
               owner_if_d  = grant_if;
               lat_cnt_d   = CNT_W'(MEM_LATENCY - 1);
               mem_en_d    = 1'b1;
               mem_we_d    = grant_dm && dm_we;
               mem_addr_d  = grant_if ? if_addr : dm_addr;
               mem_wdata_d = grant_dm ? dm_wdata : '0;
            end
         end
         ACCESS: begin
            if (lat_cnt_q == '0) begin
               if (!mem_we_q) begin
                  if (owner_if_q) begin
                     if_rdata_d = mem_rdata;
                  end else begin
                     dm_rdata_d = mem_rdata;
                  end
               end
               // Memory-side outputs return to zero as the access ends.
               state_d     = RESP;
               mem_en_d    = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               if_ack_d    = owner_if_q;
               dm_ack_d    = !owner_if_q;
            end else begin
               lat_cnt_d = lat_cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lat_cnt_q   <= '0;
         owner_if_q  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
`ifdef ARB_STARVE_GUARD_EN
         starve_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         owner_if_q  <= owner_if_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
         starve_cnt_q <= starve_cnt_d;
`endif
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=2, STARVE_LIMIT=2.
// Starvation expectations follow ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        dm_stall;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(2)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic seen_if_ack;

      rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_mem_en",   {31'd0, mem_en},   32'd0);
      chk("rst_mem_addr", mem_addr,          32'd0);
      chk("rst_if_ack",   {31'd0, if_ack},   32'd0);
      chk("rst_dm_ack",   {31'd0, dm_ack},   32'd0);
      chk("rst_if_rdata", if_rdata,          32'd0);
      chk("rst_dm_rdata", dm_rdata,          32'd0);
      step();

      // Fetch alone
      $display("txn fetch_alone: addr=0x10 rdata=deadbeef");
      if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("f_c0_stall", {31'd0, if_stall}, 32'd1);
      chk("f_c0_mem_en", {31'd0, mem_en}, 32'd0);
      step();
      chk("f_c1_mem_en", {31'd0, mem_en}, 32'd1);
      chk("f_c1_mem_addr", mem_addr, 32'h10);
      chk("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
      if_addr = 32'h99;
      step();
      chk("f_c2_mem_en", {31'd0, mem_en}, 32'd1);
      chk("f_c2_addr_held", mem_addr, 32'h10);
      chk("f_c2_stall", {31'd0, if_stall}, 32'd1);
      step();
      chk("f_c3_ack", {31'd0, if_ack}, 32'd1);
      chk("f_c3_rdata", if_rdata, 32'hDEADBEEF);
      chk("f_c3_stall", {31'd0, if_stall}, 32'd0);
      chk("f_c3_mem_en", {31'd0, mem_en}, 32'd0);
      chk("f_c3_mem_addr", mem_addr, 32'd0);
      step();
      if_req = 1'b0;
      #1;
      chk("f_c4_ack", {31'd0, if_ack}, 32'd0);
      chk("f_c4_rdata_hold", if_rdata, 32'hDEADBEEF);

      // Data write
      $display("txn data_write: addr=0x40 wdata=1234");
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234;
      mem_rdata = 32'hCAFEF00D;
      #1;
      chk("w_c0_stall", {31'd0, dm_stall}, 32'd1);
      step();
      chk("w_c1_mem_we", {31'd0, mem_we}, 32'd1);
      chk("w_c1_mem_addr", mem_addr, 32'h40);
      chk("w_c1_mem_wdata", mem_wdata, 32'h1234);
      step();
      chk("w_c2_mem_we", {31'd0, mem_we}, 32'd1);
      chk("w_c2_dm_ack", {31'd0, dm_ack}, 32'd0);
      step();
      chk("w_c3_dm_ack", {31'd0, dm_ack}, 32'd1);
      chk("w_c3_rdata_unchanged", dm_rdata, 32'd0);
      chk("w_c3_mem_we", {31'd0, mem_we}, 32'd0);
      chk("w_c3_mem_wdata", mem_wdata, 32'd0);
      step();
      dm_req = 1'b0; dm_we = 1'b0;
      #1;

      // Collision: data read wins, fetch follows
      $display("txn collision: dm_addr=0x80 if_addr=0x20");
      if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_addr = 32'h80;
      mem_rdata = 32'h11112222;
      #1;
      step();
      chk("c_c1_mem_addr", mem_addr, 32'h80);
      chk("c_c1_if_stall", {31'd0, if_stall}, 32'd1);
      step(); step();
      chk("c_c3_dm_ack", {31'd0, dm_ack}, 32'd1);
      chk("c_c3_dm_rdata", dm_rdata, 32'h11112222);
      chk("c_c3_if_ack", {31'd0, if_ack}, 32'd0);
      step();
      dm_req = 1'b0; mem_rdata = 32'h33334444;
      #1;
      chk("c_c4_bubble", {31'd0, mem_en}, 32'd0);
      step();
      chk("c_c5_mem_addr", mem_addr, 32'h20);
      step(); step();
      chk("c_c7_if_ack", {31'd0, if_ack}, 32'd1);
      chk("c_c7_if_rdata", if_rdata, 32'h33334444);
      chk("c_c7_dm_rdata_hold", dm_rdata, 32'h11112222);
      step();
      if_req = 1'b0;
      #1;

      // Starvation: data requests continuously while fetch waits
      $display("txn starvation: if_addr=0x30 dm_addr=0x50");
      if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
      mem_rdata = 32'h0BADF00D;
      #1;
      step();
      chk("s_c1_mem_addr", mem_addr, 32'h50);
      step(); step(); step(); step();
      chk("s_c5_mem_addr", mem_addr, 32'h50);
      step(); step(); step(); step();
`ifdef ARB_STARVE_GUARD_EN
      chk("s_c9_mem_addr", mem_addr, 32'h30);
      step(); step();
      chk("s_c11_if_ack", {31'd0, if_ack}, 32'd1);
      step();
      if_req = 1'b0;
      #1;
      step();
      chk("s_c13_mem_addr", mem_addr, 32'h50);
`else
      chk("s_c9_mem_addr", mem_addr, 32'h50);
      seen_if_ack = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         seen_if_ack = seen_if_ack | if_ack;
      end
      chk("s_no_if_ack", {31'd0, seen_if_ack}, 32'd0);
`endif
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
      step();
      rst = 1'b0;
      #1;
      chk("s_rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("s_rst_dm_rdata", dm_rdata, 32'd0);
      step();

      // Reset in the middle of a data read with dm_req held
      $display("txn reset_mid_access: dm_addr=0x60");
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60; mem_rdata = 32'h55AA55AA;
      #1;
      step();
      chk("r_c1_mem_en", {31'd0, mem_en}, 32'd1);
      step();
      rst = 1'b1;
      #1;
      chk("r_c2_mem_en", {31'd0, mem_en}, 32'd1);
      step();
      rst = 1'b0;
      #1;
      chk("r_c3_mem_en", {31'd0, mem_en}, 32'd0);
      chk("r_c3_dm_ack", {31'd0, dm_ack}, 32'd0);
      chk("r_c3_dm_rdata", dm_rdata, 32'd0);
      chk("r_c3_dm_stall", {31'd0, dm_stall}, 32'd1);
      step();
      chk("r_c4_mem_en", {31'd0, mem_en}, 32'd1);
      chk("r_c4_mem_addr", mem_addr, 32'h60);
      chk("r_c4_dm_ack", {31'd0, dm_ack}, 32'd0);
      step();
      chk("r_c5_dm_ack", {31'd0, dm_ack}, 32'd0);
      step();
      chk("r_c6_dm_ack", {31'd0, dm_ack}, 32'd1);
      chk("r_c6_dm_rdata", dm_rdata, 32'h55AA55AA);
      step();
      dm_req = 1'b0;
      #1;
      chk("r_c7_dm_ack", {31'd0, dm_ack}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
